// File: rtl/cavlc_mb_scheduler_if.sv
// Handshake and data bus between the CAVLC macroblock scheduler and its environment.
// The slave modport is used by the scheduler. The master modport is used by the stimulus side.
interface cavlc_mb_scheduler_if;
  logic        Start;
  logic [3:0]  CbpLuma;
  logic        LeftAvail;
  logic        TopAvail;
  logic [19:0] LeftTC;
  logic [19:0] TopTC;
  logic        BarrelShifterReady;
  logic        CoreBlockDone;
  logic [4:0]  CoreTotalCoeff;
  logic        CoreEnable;
  logic [4:0]  nC;
  logic [3:0]  BlkIdx;
  logic        Busy;
  logic        MbDone;
  logic [19:0] RightColTC;
  logic [19:0] BottomRowTC;

  modport master (
    output Start, CbpLuma, LeftAvail, TopAvail, LeftTC, TopTC,
           BarrelShifterReady, CoreBlockDone, CoreTotalCoeff,
    input  CoreEnable, nC, BlkIdx, Busy, MbDone, RightColTC, BottomRowTC
  );

  modport slave (
    input  Start, CbpLuma, LeftAvail, TopAvail, LeftTC, TopTC,
           BarrelShifterReady, CoreBlockDone, CoreTotalCoeff,
    output CoreEnable, nC, BlkIdx, Busy, MbDone, RightColTC, BottomRowTC
  );
endinterface

// File: rtl/cavlc_mb_scheduler.sv
// Runs the CAVLC block decoder over the 16 luma 4x4 blocks of a macroblock in 8x8-quadrant scan order.
// It derives nC for each block from neighbour TotalCoeff values and records each block's TotalCoeff.
module cavlc_mb_scheduler #(
  parameter int NUM_BLK = 16,
  parameter int TC_W    = 5
) (
  input logic                 Clk,
  input logic                 nReset,
  cavlc_mb_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    RUN,
    NEXT,
    DONE
  } state_t;

  state_t            state, stateNext;
  logic [3:0]        blk;
  logic [3:0]        cbpReg;
  logic              leftAvailReg;
  logic              topAvailReg;
  logic [19:0]       leftTcReg;
  logic [19:0]       topTcReg;
  logic [TC_W-1:0]   tc [NUM_BLK];
  logic [TC_W-1:0]   ncReg;
  logic              mbDoneReg;

  logic [1:0]        x, y, xm1, ym1;
  logic              aAvail, bAvail;
  logic [TC_W-1:0]   nA, nB, ncCalc;
  logic [TC_W:0]     sum6;

  function automatic logic [TC_W-1:0] pickTc(input logic [19:0] v, input logic [1:0] i);
    logic [TC_W-1:0] r;
    case (i)
      2'd0:    r = v[4:0];
      2'd1:    r = v[9:5];
      2'd2:    r = v[14:10];
      default: r = v[19:15];
    endcase
    return r;
  endfunction

  // Block index bits interleave as {y[1], x[1], y[0], x[0]}. Left and above neighbours are re-encoded that way.
  always_comb begin
    x      = {blk[2], blk[0]};
    y      = {blk[3], blk[1]};
    xm1    = x - 2'd1;
    ym1    = y - 2'd1;
    aAvail = (x != 2'd0) || leftAvailReg;
    bAvail = (y != 2'd0) || topAvailReg;
    nA     = (x != 2'd0) ? tc[{y[1], xm1[1], y[0], xm1[0]}] : pickTc(leftTcReg, y);
    nB     = (y != 2'd0) ? tc[{ym1[1], x[1], ym1[0], x[0]}] : pickTc(topTcReg, x);
    sum6   = {1'b0, nA} + {1'b0, nB} + (TC_W+1)'(1);
    case ({aAvail, bAvail})
      2'b11:   ncCalc = TC_W'(sum6 >> 1);
      2'b10:   ncCalc = nA;
      2'b01:   ncCalc = nB;
      default: ncCalc = '0;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.Start) stateNext = SELECT;
      SELECT:  stateNext = cbpReg[blk[3:2]] ? ISSUE : NEXT;
      ISSUE:   if (bus.BarrelShifterReady) stateNext = RUN;
      RUN:     if (bus.CoreBlockDone) stateNext = NEXT;
      NEXT:    stateNext = (blk == 4'd15) ? DONE : SELECT;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      blk          <= '0;
      cbpReg       <= '0;
      leftAvailReg <= 1'b0;
      topAvailReg  <= 1'b0;
      leftTcReg    <= '0;
      topTcReg     <= '0;
      ncReg        <= '0;
      mbDoneReg    <= 1'b0;
    end else begin
      state     <= stateNext;
      mbDoneReg <= (state == DONE);
      if (state == IDLE && bus.Start) begin
        blk          <= '0;
        cbpReg       <= bus.CbpLuma;
        leftAvailReg <= bus.LeftAvail;
        topAvailReg  <= bus.TopAvail;
        leftTcReg    <= bus.LeftTC;
        topTcReg     <= bus.TopTC;
      end
      if (state == SELECT && cbpReg[blk[3:2]]) ncReg <= ncCalc;
      if (state == NEXT && blk != 4'd15) blk <= blk + 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned i = 0; i < NUM_BLK; i++) tc[i] <= '0;
    end else if (state == IDLE && bus.Start) begin
      for (int unsigned i = 0; i < NUM_BLK; i++) tc[i] <= '0;
    end else if (state == SELECT && !cbpReg[blk[3:2]]) begin
      tc[blk] <= '0;
    end else if (state == RUN && bus.CoreBlockDone) begin
      tc[blk] <= bus.CoreTotalCoeff;
    end
  end

  assign bus.CoreEnable  = (state == ISSUE);
  assign bus.Busy        = (state != IDLE);
  assign bus.BlkIdx      = (state == IDLE) ? 4'd0 : blk;
  assign bus.nC          = ncReg;
  assign bus.MbDone      = mbDoneReg;
  assign bus.RightColTC  = {tc[15], tc[13], tc[7], tc[5]};
  assign bus.BottomRowTC = {tc[15], tc[14], tc[11], tc[10]};

endmodule

// File: tb/tb_cavlc_mb_scheduler.sv
// Scoreboard bench for cavlc_mb_scheduler. Expected (block, nC) pairs are queued per macroblock from an x/y model.
// The expected pairs are popped as the scheduler issues blocks.
module tb_cavlc_mb_scheduler;
  logic Clk = 1'b0;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  cavlc_mb_scheduler_if bus ();

  cavlc_mb_scheduler #(.NUM_BLK(16), .TC_W(5)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  int nCompared = 0;
  int nMismatch = 0;
  int cycCnt = 0;
  always @(posedge Clk) cycCnt++;

  logic [4:0]  tcRet [16];
  logic [4:0]  tcXY [4][4];
  logic [3:0]  expBlk [$];
  logic [4:0]  expNc [$];
  logic [19:0] expRight, expBottom;

  function automatic int pick(input logic [19:0] v, input int i);
    logic [4:0] r;
    r = v[5*i +: 5];
    return int'(r);
  endfunction

  task automatic build_model(input logic [3:0] cbp, input logic la, input logic ta,
                             input logic [19:0] ltc, input logic [19:0] ttc);
    expBlk.delete();
    expNc.delete();
    for (int b = 0; b < 16; b++) begin
      int x, y, a, t, nc;
      x = (b & 1) + 2 * ((b >> 2) & 1);
      y = ((b >> 1) & 1) + 2 * ((b >> 3) & 1);
      if (!cbp[b >> 2]) begin
        tcXY[x][y] = 5'd0;
      end else begin
        a = -1;
        t = -1;
        if (x > 0) a = int'(tcXY[x-1][y]);
        else if (la) a = pick(ltc, y);
        if (y > 0) t = int'(tcXY[x][y-1]);
        else if (ta) t = pick(ttc, x);
        if (a >= 0 && t >= 0) nc = (a + t + 1) / 2;
        else if (a >= 0) nc = a;
        else if (t >= 0) nc = t;
        else nc = 0;
        expBlk.push_back(4'(b));
        expNc.push_back(5'(nc));
        tcXY[x][y] = tcRet[b];
      end
    end
    expRight  = {tcXY[3][3], tcXY[3][2], tcXY[3][1], tcXY[3][0]};
    expBottom = {tcXY[3][3], tcXY[2][3], tcXY[1][3], tcXY[0][3]};
  endtask

  // Drives one macroblock; abortBlk >= 0 pulls reset during RUN of that block.
  task automatic run_mb(input logic [3:0] cbp, input logic la, input logic ta,
                        input logic [19:0] ltc, input logic [19:0] ttc,
                        input int readyDelay, input bit startInRun,
                        input int abortBlk, input int expLat);
    int startCyc, guard;
    bit done, firstIssue, bad;
    logic [3:0] blk;
    logic [4:0] ncExp;
    build_model(cbp, la, ta, ltc, ttc);
    @(negedge Clk);
    bus.Start = 1'b1; bus.CbpLuma = cbp; bus.LeftAvail = la; bus.TopAvail = ta;
    bus.LeftTC = ltc; bus.TopTC = ttc;
    @(negedge Clk);
    bus.Start = 1'b0; bus.CbpLuma = ~cbp; bus.LeftTC = '0; bus.TopTC = '0;
    startCyc = cycCnt - 1;
    done = 1'b0; guard = 0; firstIssue = 1'b1;
    while (!done && guard < 3000) begin
      if (bus.MbDone) begin
        done = 1'b1;
        nCompared++;
        if (expBlk.size() !== 0) begin
          nMismatch++; $display("FAIL blocks_issued: %0d blocks left unissued, required 0", expBlk.size());
        end
        nCompared++;
        if (bus.RightColTC !== expRight) begin
          nMismatch++; $display("FAIL RightColTC: got %h required %h", bus.RightColTC, expRight);
        end
        nCompared++;
        if (bus.BottomRowTC !== expBottom) begin
          nMismatch++; $display("FAIL BottomRowTC: got %h required %h", bus.BottomRowTC, expBottom);
        end
        if (expLat >= 0) begin
          nCompared++;
          if (cycCnt - startCyc !== expLat) begin
            nMismatch++; $display("FAIL mbdone_latency: got %0d required %0d", cycCnt - startCyc, expLat);
          end
        end
      end else if (bus.CoreEnable) begin
        if (expBlk.size() == 0) begin
          nCompared++; nMismatch++;
          $display("FAIL unexpected_issue: CoreEnable high for BlkIdx %0d, required no issue", bus.BlkIdx);
          done = 1'b1;
        end else begin
          blk = expBlk.pop_front();
          ncExp = expNc.pop_front();
          if (firstIssue && cbp[0]) begin
            nCompared++;
            if (cycCnt - startCyc !== 2) begin
              nMismatch++; $display("FAIL issue_latency: got %0d required 2", cycCnt - startCyc);
            end
          end
          firstIssue = 1'b0;
          nCompared++;
          if (bus.BlkIdx !== blk) begin
            nMismatch++; $display("FAIL BlkIdx: got %0d required %0d", bus.BlkIdx, blk);
          end
          nCompared++;
          if (bus.nC !== ncExp) begin
            nMismatch++; $display("FAIL nC_blk%0d: got %0d required %0d", blk, bus.nC, ncExp);
          end
          for (int i = 0; i < readyDelay; i++) begin
            @(negedge Clk); guard++;
            nCompared++;
            if (bus.CoreEnable !== 1'b1 || bus.nC !== ncExp) begin
              nMismatch++;
              $display("FAIL issue_hold: CoreEnable=%b nC=%0d required 1 and %0d", bus.CoreEnable, bus.nC, ncExp);
            end
          end
          bus.BarrelShifterReady = 1'b1;
          @(negedge Clk);
          bus.BarrelShifterReady = 1'b0;
          nCompared++;
          if (bus.CoreEnable !== 1'b0 || bus.BlkIdx !== blk || bus.nC !== ncExp) begin
            nMismatch++;
            $display("FAIL run_entry: CoreEnable=%b BlkIdx=%0d nC=%0d required 0, %0d, %0d",
                     bus.CoreEnable, bus.BlkIdx, bus.nC, blk, ncExp);
          end
          if (abortBlk == int'(blk)) begin
            #2 nReset = 1'b0;
            #1;
            nCompared++;
            if (bus.Busy !== 1'b0 || bus.CoreEnable !== 1'b0 || bus.RightColTC !== 20'd0) begin
              nMismatch++;
              $display("FAIL async_reset: Busy=%b CoreEnable=%b RightColTC=%h required 0 0 0",
                       bus.Busy, bus.CoreEnable, bus.RightColTC);
            end
            @(negedge Clk);
            nReset = 1'b1;
            bad = 1'b0;
            for (int i = 0; i < 40; i++) begin
              @(negedge Clk);
              if (bus.MbDone !== 1'b0 || bus.Busy !== 1'b0) bad = 1'b1;
            end
            nCompared++;
            if (bad) begin
              nMismatch++; $display("FAIL post_reset_idle: MbDone or Busy seen high, required both 0");
            end
            return;
          end
          if (startInRun) begin
            bus.Start = 1'b1; bus.CbpLuma = 4'h0;
            @(negedge Clk);
            bus.Start = 1'b0;
            nCompared++;
            if (bus.BlkIdx !== blk || bus.CoreEnable !== 1'b0) begin
              nMismatch++;
              $display("FAIL start_in_run: BlkIdx=%0d CoreEnable=%b required %0d and 0", bus.BlkIdx, bus.CoreEnable, blk);
            end
          end else begin
            @(negedge Clk);
          end
          bus.CoreBlockDone = 1'b1;
          bus.CoreTotalCoeff = tcRet[blk];
          @(negedge Clk);
          bus.CoreBlockDone = 1'b0;
          bus.CoreTotalCoeff = 5'd0;
        end
      end else begin
        @(negedge Clk);
        guard++;
      end
    end
    if (!done) begin
      nCompared++; nMismatch++;
      $display("FAIL timeout: no MbDone within cycle budget, required MbDone");
    end
  endtask

  task automatic test_reset;
    #23;
    nCompared++;
    if (bus.Busy !== 1'b0 || bus.CoreEnable !== 1'b0 || bus.MbDone !== 1'b0) begin
      nMismatch++;
      $display("FAIL reset_ctrl: Busy=%b CoreEnable=%b MbDone=%b required 0 0 0", bus.Busy, bus.CoreEnable, bus.MbDone);
    end
    nCompared++;
    if (bus.BlkIdx !== 4'd0 || bus.nC !== 5'd0) begin
      nMismatch++; $display("FAIL reset_idx_nc: BlkIdx=%0d nC=%0d required 0 0", bus.BlkIdx, bus.nC);
    end
    nCompared++;
    if (bus.RightColTC !== 20'd0 || bus.BottomRowTC !== 20'd0) begin
      nMismatch++;
      $display("FAIL reset_tc: RightColTC=%h BottomRowTC=%h required 0 0", bus.RightColTC, bus.BottomRowTC);
    end
    @(negedge Clk);
    nReset = 1'b1;
  endtask

  task automatic test_all_skipped;
    for (int b = 0; b < 16; b++) tcRet[b] = 5'(b + 1);
    run_mb(4'h0, 1'b1, 1'b1, 20'hFFFFF, 20'hFFFFF, 0, 1'b0, -1, 34);
  endtask

  task automatic test_full_no_neighbours;
    for (int b = 0; b < 16; b++) tcRet[b] = 5'(b);
    run_mb(4'hF, 1'b0, 1'b0, 20'd0, 20'd0, 0, 1'b0, -1, -1);
  endtask

  task automatic test_left_only;
    for (int b = 0; b < 16; b++) tcRet[b] = 5'd0;
    run_mb(4'h1, 1'b1, 1'b0, {15'd0, 5'd7}, 20'hFFFFF, 0, 1'b0, -1, -1);
  endtask

  task automatic test_both_sum;
    logic [19:0] ltc, ttc;
    for (int b = 0; b < 16; b++) tcRet[b] = 5'($urandom_range(16));
    for (int i = 0; i < 4; i++) begin
      ltc[5*i +: 5] = 5'($urandom_range(16));
      ttc[5*i +: 5] = 5'($urandom_range(16));
    end
    ltc[4:0] = 5'd3;
    ttc[4:0] = 5'd16;
    run_mb(4'hF, 1'b1, 1'b1, ltc, ttc, 0, 1'b0, -1, -1);
  endtask

  task automatic test_ready_stall;
    for (int b = 0; b < 16; b++) tcRet[b] = 5'($urandom_range(16));
    run_mb(4'b1010, 1'b1, 1'b1, 20'h8C631, 20'h2108A, 5, 1'b1, -1, -1);
  endtask

  task automatic test_reset_mid;
    for (int b = 0; b < 16; b++) tcRet[b] = 5'(b);
    run_mb(4'hF, 1'b0, 1'b0, 20'd0, 20'd0, 0, 1'b0, 6, -1);
    for (int b = 0; b < 16; b++) tcRet[b] = 5'(16 - b);
    run_mb(4'hF, 1'b0, 1'b0, 20'd0, 20'd0, 0, 1'b0, -1, -1);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      logic [19:0] ltc, ttc;
      for (int b = 0; b < 16; b++) tcRet[b] = 5'($urandom_range(16));
      for (int i = 0; i < 4; i++) begin
        ltc[5*i +: 5] = 5'($urandom_range(16));
        ttc[5*i +: 5] = 5'($urandom_range(16));
      end
      run_mb(4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             ltc, ttc, int'($urandom_range(2)), 1'b0, -1, -1);
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.CbpLuma = '0; bus.LeftAvail = 1'b0; bus.TopAvail = 1'b0;
    bus.LeftTC = '0; bus.TopTC = '0; bus.BarrelShifterReady = 1'b0;
    bus.CoreBlockDone = 1'b0; bus.CoreTotalCoeff = '0;
    test_reset();
    test_all_skipped();
    test_full_no_neighbours();
    test_left_only();
    test_both_sum();
    test_ready_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
